// File: rtl/axi4_register_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi4_register_slice                                          |
// | Description : AXI4 five-channel register slice, per-channel selectable     |
// |               pass-through, forward register or full skid buffer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module axi4_register_slice #(
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int USER_W  = 1,
   parameter int AW_MODE = 2,
   parameter int W_MODE  = 2,
   parameter int B_MODE  = 2,
   parameter int AR_MODE = 2,
   parameter int R_MODE  = 2,
   localparam int AW_PW  = ID_W + ADDR_W + USER_W + 29,
   localparam int AR_PW  = ID_W + ADDR_W + USER_W + 29,
   localparam int W_PW   = DATA_W + DATA_W / 8 + 1 + USER_W,
   localparam int B_PW   = ID_W + 2 + USER_W,
   localparam int R_PW   = ID_W + DATA_W + 3 + USER_W
) (
   input  logic             ACLK,
   input  logic             ARESETn,

   input  logic             aw_in_valid,
   output logic             aw_in_ready,
   input  logic [AW_PW-1:0] aw_in_data,
   output logic             aw_out_valid,
   input  logic             aw_out_ready,
   output logic [AW_PW-1:0] aw_out_data,

   input  logic             w_in_valid,
   output logic             w_in_ready,
   input  logic [W_PW-1:0]  w_in_data,
   output logic             w_out_valid,
   input  logic             w_out_ready,
   output logic [W_PW-1:0]  w_out_data,

   input  logic             b_in_valid,
   output logic             b_in_ready,
   input  logic [B_PW-1:0]  b_in_data,
   output logic             b_out_valid,
   input  logic             b_out_ready,
   output logic [B_PW-1:0]  b_out_data,

   input  logic             ar_in_valid,
   output logic             ar_in_ready,
   input  logic [AR_PW-1:0] ar_in_data,
   output logic             ar_out_valid,
   input  logic             ar_out_ready,
   output logic [AR_PW-1:0] ar_out_data,

   input  logic             r_in_valid,
   output logic             r_in_ready,
   input  logic [R_PW-1:0]  r_in_data,
   output logic             r_out_valid,
   input  logic             r_out_ready,
   output logic [R_PW-1:0]  r_out_data,

   output logic             idle
);

   logic w_aw_busy;
   logic w_w_busy;
   logic w_b_busy;
   logic w_ar_busy;
   logic w_r_busy;

   axi4_register_slice_chan #(.W(AW_PW), .MODE(AW_MODE)) u_aw (
      .clk         (ACLK),
      .rst_n       (ARESETn),
      .i_in_valid  (aw_in_valid),
      .o_in_ready  (aw_in_ready),
      .i_in_data   (aw_in_data),
      .o_out_valid (aw_out_valid),
      .i_out_ready (aw_out_ready),
      .o_out_data  (aw_out_data),
      .o_busy      (w_aw_busy)
   );

   axi4_register_slice_chan #(.W(W_PW), .MODE(W_MODE)) u_w (
      .clk         (ACLK),
      .rst_n       (ARESETn),
      .i_in_valid  (w_in_valid),
      .o_in_ready  (w_in_ready),
      .i_in_data   (w_in_data),
      .o_out_valid (w_out_valid),
      .i_out_ready (w_out_ready),
      .o_out_data  (w_out_data),
      .o_busy      (w_w_busy)
   );

   axi4_register_slice_chan #(.W(B_PW), .MODE(B_MODE)) u_b (
      .clk         (ACLK),
      .rst_n       (ARESETn),
      .i_in_valid  (b_in_valid),
      .o_in_ready  (b_in_ready),
      .i_in_data   (b_in_data),
      .o_out_valid (b_out_valid),
      .i_out_ready (b_out_ready),
      .o_out_data  (b_out_data),
      .o_busy      (w_b_busy)
   );

   axi4_register_slice_chan #(.W(AR_PW), .MODE(AR_MODE)) u_ar (
      .clk         (ACLK),
      .rst_n       (ARESETn),
      .i_in_valid  (ar_in_valid),
      .o_in_ready  (ar_in_ready),
      .i_in_data   (ar_in_data),
      .o_out_valid (ar_out_valid),
      .i_out_ready (ar_out_ready),
      .o_out_data  (ar_out_data),
      .o_busy      (w_ar_busy)
   );

   axi4_register_slice_chan #(.W(R_PW), .MODE(R_MODE)) u_r (
      .clk         (ACLK),
      .rst_n       (ARESETn),
      .i_in_valid  (r_in_valid),
      .o_in_ready  (r_in_ready),
      .i_in_data   (r_in_data),
      .o_out_valid (r_out_valid),
      .i_out_ready (r_out_ready),
      .o_out_data  (r_out_data),
      .o_busy      (w_r_busy)
   );

   assign idle = !(w_aw_busy || w_w_busy || w_b_busy || w_ar_busy || w_r_busy);

endmodule

// +----------------------------------------------------------------------------+
// | Module      : axi4_register_slice_chan                                     |
// | Description : One valid/ready channel slice; MODE 0 wire, 1 forward       |
// |               register, 2 two-entry skid buffer.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module axi4_register_slice_chan #(
   parameter int W    = 8,
   parameter int MODE = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_out_data,
   output logic         o_busy
);

   generate
      if (MODE == 0) begin : g_pass
         assign o_out_valid = i_in_valid;
         assign o_out_data  = i_in_data;
         assign o_in_ready  = i_out_ready;
         assign o_busy      = 1'b0;
      end else if (MODE == 1) begin : g_fwd
         logic         r_valid;
         logic [W-1:0] r_data;
         logic         w_ready;

         assign w_ready = !r_valid || i_out_ready;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
            end else if (w_ready) begin
               r_valid <= i_in_valid;
            end
         end

         // Payload carries no reset; it is qualified by r_valid.
         always_ff @(posedge clk) begin
            if (w_ready && i_in_valid) begin
               r_data <= i_in_data;
            end
         end

         assign o_in_ready  = w_ready;
         assign o_out_valid = r_valid;
         assign o_out_data  = r_data;
         assign o_busy      = r_valid;
      end else begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_FULL  = 2'd2
         } state_t;

         state_t       r_state;
         state_t       w_state_nxt;
         logic         r_in_ready;
         logic         r_out_valid;
         logic [W-1:0] r_main;
         logic [W-1:0] r_skid;
         logic         w_in_xfer;
         logic         w_out_xfer;
         logic         w_load_main;
         logic         w_load_skid;
         logic         w_main_from_skid;

         assign w_in_xfer  = i_in_valid && r_in_ready;
         assign w_out_xfer = r_out_valid && i_out_ready;

         always_comb begin
            w_state_nxt      = r_state;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
            case (r_state)
               ST_EMPTY: begin
                  if (w_in_xfer) begin
                     w_state_nxt = ST_ONE;
                     w_load_main = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (w_in_xfer && !w_out_xfer) begin
                     w_state_nxt = ST_FULL;
                     w_load_skid = 1'b1;
                  end else if (!w_in_xfer && w_out_xfer) begin
                     w_state_nxt = ST_EMPTY;
                  end else if (w_in_xfer && w_out_xfer) begin
                     w_load_main = 1'b1;
                  end
               end
               ST_FULL: begin
                  if (w_out_xfer) begin
                     w_state_nxt      = ST_ONE;
                     w_main_from_skid = 1'b1;
                  end
               end
               default: begin
                  w_state_nxt = ST_EMPTY;
               end
            endcase
         end

         // Handshake outputs come straight from flops, decoded from the next state.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
            end else begin
               r_state     <= w_state_nxt;
               r_in_ready  <= (w_state_nxt != ST_FULL);
               r_out_valid <= (w_state_nxt != ST_EMPTY);
            end
         end

         always_ff @(posedge clk) begin
            if (w_main_from_skid) begin
               r_main <= r_skid;
            end else if (w_load_main) begin
               r_main <= i_in_data;
            end
            if (w_load_skid) begin
               r_skid <= i_in_data;
            end
         end

         assign o_in_ready  = r_in_ready;
         assign o_out_valid = r_out_valid;
         assign o_out_data  = r_main;
         assign o_busy      = r_out_valid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_register_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi4_register_slice                                       |
// | Description : Scoreboard bench for axi4_register_slice, mixed-mode and     |
// |               all-pass-through instances.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`define CHK(NAME, ACT, EXP) chk(NAME, 256'(ACT), 256'(EXP))

module tb_axi4_register_slice;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int USER_W = 1;
    localparam int AW_PW  = ID_W + ADDR_W + USER_W + 29;
    localparam int W_PW   = DATA_W + DATA_W / 8 + 1 + USER_W;
    localparam int B_PW   = ID_W + 2 + USER_W;
    localparam int R_PW   = ID_W + DATA_W + 3 + USER_W;
    localparam int M_AW_PW = 1 + 12 + 1 + 29;
    localparam int M_W_PW  = 8 + 1 + 1 + 1;
    localparam int M_B_PW  = 1 + 2 + 1;
    localparam int M_R_PW  = 1 + 8 + 3 + 1;

    logic clk = 1'b0;
    logic ARESETn;
    always #5 clk = ~clk;

    logic aw_in_valid, aw_in_ready, aw_out_valid, aw_out_ready;
    logic w_in_valid,  w_in_ready,  w_out_valid,  w_out_ready;
    logic b_in_valid,  b_in_ready,  b_out_valid,  b_out_ready;
    logic ar_in_valid, ar_in_ready, ar_out_valid, ar_out_ready;
    logic r_in_valid,  r_in_ready,  r_out_valid,  r_out_ready;
    logic [AW_PW-1:0] aw_in_data, aw_out_data, ar_in_data, ar_out_data;
    logic [W_PW-1:0]  w_in_data,  w_out_data;
    logic [B_PW-1:0]  b_in_data,  b_out_data;
    logic [R_PW-1:0]  r_in_data,  r_out_data;
    logic idle;

    logic m0_aw_in_valid, m0_aw_in_ready, m0_aw_out_valid, m0_aw_out_ready;
    logic m0_w_in_valid,  m0_w_in_ready,  m0_w_out_valid,  m0_w_out_ready;
    logic m0_b_in_valid,  m0_b_in_ready,  m0_b_out_valid,  m0_b_out_ready;
    logic m0_ar_in_valid, m0_ar_in_ready, m0_ar_out_valid, m0_ar_out_ready;
    logic m0_r_in_valid,  m0_r_in_ready,  m0_r_out_valid,  m0_r_out_ready;
    logic [M_AW_PW-1:0] m0_aw_in_data, m0_aw_out_data, m0_ar_in_data, m0_ar_out_data;
    logic [M_W_PW-1:0]  m0_w_in_data,  m0_w_out_data;
    logic [M_B_PW-1:0]  m0_b_in_data,  m0_b_out_data;
    logic [M_R_PW-1:0]  m0_r_in_data,  m0_r_out_data;
    logic m0_idle;

    int n_chk  = 0;
    int n_pass = 0;
    bit rr_en  = 1'b0;

    logic [255:0] mq [5][$];
    logic [255:0] mhold [5];
    bit           mstall [5];
    string        mname [5] = '{"aw", "w", "b", "ar", "r"};

    axi4_register_slice #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W),
        .AW_MODE(2), .W_MODE(1), .B_MODE(2), .AR_MODE(2), .R_MODE(2)
    ) dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .aw_in_valid(aw_in_valid), .aw_in_ready(aw_in_ready), .aw_in_data(aw_in_data),
        .aw_out_valid(aw_out_valid), .aw_out_ready(aw_out_ready), .aw_out_data(aw_out_data),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
        .w_out_valid(w_out_valid), .w_out_ready(w_out_ready), .w_out_data(w_out_data),
        .b_in_valid(b_in_valid), .b_in_ready(b_in_ready), .b_in_data(b_in_data),
        .b_out_valid(b_out_valid), .b_out_ready(b_out_ready), .b_out_data(b_out_data),
        .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready), .ar_in_data(ar_in_data),
        .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready), .ar_out_data(ar_out_data),
        .r_in_valid(r_in_valid), .r_in_ready(r_in_ready), .r_in_data(r_in_data),
        .r_out_valid(r_out_valid), .r_out_ready(r_out_ready), .r_out_data(r_out_data),
        .idle(idle)
    );

    axi4_register_slice #(
        .ID_W(1), .ADDR_W(12), .DATA_W(8), .USER_W(1),
        .AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0)
    ) dut0 (
        .ACLK(clk), .ARESETn(ARESETn),
        .aw_in_valid(m0_aw_in_valid), .aw_in_ready(m0_aw_in_ready), .aw_in_data(m0_aw_in_data),
        .aw_out_valid(m0_aw_out_valid), .aw_out_ready(m0_aw_out_ready), .aw_out_data(m0_aw_out_data),
        .w_in_valid(m0_w_in_valid), .w_in_ready(m0_w_in_ready), .w_in_data(m0_w_in_data),
        .w_out_valid(m0_w_out_valid), .w_out_ready(m0_w_out_ready), .w_out_data(m0_w_out_data),
        .b_in_valid(m0_b_in_valid), .b_in_ready(m0_b_in_ready), .b_in_data(m0_b_in_data),
        .b_out_valid(m0_b_out_valid), .b_out_ready(m0_b_out_ready), .b_out_data(m0_b_out_data),
        .ar_in_valid(m0_ar_in_valid), .ar_in_ready(m0_ar_in_ready), .ar_in_data(m0_ar_in_data),
        .ar_out_valid(m0_ar_out_valid), .ar_out_ready(m0_ar_out_ready), .ar_out_data(m0_ar_out_data),
        .r_in_valid(m0_r_in_valid), .r_in_ready(m0_r_in_ready), .r_in_data(m0_r_in_data),
        .r_out_valid(m0_r_out_valid), .r_out_ready(m0_r_out_ready), .r_out_data(m0_r_out_data),
        .idle(m0_idle)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic get_in_valid(input int c);
        case (c)
            0: return aw_in_valid;
            1: return w_in_valid;
            2: return b_in_valid;
            3: return ar_in_valid;
            default: return r_in_valid;
        endcase
    endfunction

    function automatic logic get_in_ready(input int c);
        case (c)
            0: return aw_in_ready;
            1: return w_in_ready;
            2: return b_in_ready;
            3: return ar_in_ready;
            default: return r_in_ready;
        endcase
    endfunction

    function automatic logic [255:0] get_in_data(input int c);
        case (c)
            0: return 256'(aw_in_data);
            1: return 256'(w_in_data);
            2: return 256'(b_in_data);
            3: return 256'(ar_in_data);
            default: return 256'(r_in_data);
        endcase
    endfunction

    function automatic logic get_out_valid(input int c);
        case (c)
            0: return aw_out_valid;
            1: return w_out_valid;
            2: return b_out_valid;
            3: return ar_out_valid;
            default: return r_out_valid;
        endcase
    endfunction

    function automatic logic get_out_ready(input int c);
        case (c)
            0: return aw_out_ready;
            1: return w_out_ready;
            2: return b_out_ready;
            3: return ar_out_ready;
            default: return r_out_ready;
        endcase
    endfunction

    function automatic logic [255:0] get_out_data(input int c);
        case (c)
            0: return 256'(aw_out_data);
            1: return 256'(w_out_data);
            2: return 256'(b_out_data);
            3: return 256'(ar_out_data);
            default: return 256'(r_out_data);
        endcase
    endfunction

    task automatic set_in(input int c, input logic v, input logic [255:0] d);
        case (c)
            0: begin aw_in_data = AW_PW'(d); aw_in_valid = v; end
            1: begin w_in_data  = W_PW'(d);  w_in_valid  = v; end
            2: begin b_in_data  = B_PW'(d);  b_in_valid  = v; end
            3: begin ar_in_data = AW_PW'(d); ar_in_valid = v; end
            default: begin r_in_data = R_PW'(d); r_in_valid = v; end
        endcase
    endtask

    task automatic set_valid(input int c, input logic v);
        case (c)
            0: aw_in_valid = v;
            1: w_in_valid  = v;
            2: b_in_valid  = v;
            3: ar_in_valid = v;
            default: r_in_valid = v;
        endcase
    endtask

    task automatic mon(input int c);
        logic [255:0] e;
        logic         ov;
        logic [255:0] od;
        if (!ARESETn) begin
            mq[c].delete();
            mstall[c] = 1'b0;
        end else begin
            ov = get_out_valid(c);
            od = get_out_data(c);
            if (mstall[c]) begin
                n_chk++;
                if (ov === 1'b1) n_pass++;
                else $display("FAIL %s stall valid: got %0h expected 1", mname[c], ov);
                n_chk++;
                if (od === mhold[c]) n_pass++;
                else $display("FAIL %s stall data: got %0h expected %0h", mname[c], od, mhold[c]);
            end
            if (get_in_valid(c) && get_in_ready(c)) mq[c].push_back(get_in_data(c));
            if (ov && get_out_ready(c)) begin
                `CHK({mname[c], " beat expected"}, mq[c].size() != 0, 1'b1);
                if (mq[c].size() != 0) begin
                    e = mq[c].pop_front();
                    n_chk++;
                    if (od === e) n_pass++;
                    else $display("FAIL %s beat data: got %0h expected %0h", mname[c], od, e);
                end
            end
            mstall[c] = ov && !get_out_ready(c);
            mhold[c]  = od;
        end
    endtask

    task automatic drv(input int c, input int nb);
        bit acc;
        for (int n = 0; n < nb; n++) begin
            while ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
            set_in(c, 1'b1, rnd());
            acc = 1'b0;
            for (int t = 0; t < 1000 && !acc; t++) begin
                @(negedge clk); acc = get_in_ready(c); @(posedge clk); #1;
            end
            set_valid(c, 1'b0);
            if (!acc) begin
                `CHK({mname[c], " accept timeout"}, acc, 1'b1);
                n = nb;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 5; c++) mon(c);
    end

    always @(posedge clk) begin
        #1;
        if (rr_en) begin
            aw_out_ready = 1'($urandom_range(0, 1));
            w_out_ready  = 1'($urandom_range(0, 1));
            b_out_ready  = 1'($urandom_range(0, 1));
            ar_out_ready = 1'($urandom_range(0, 1));
            r_out_ready  = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] pv;
        ARESETn = 1'b1;
        {aw_in_valid, w_in_valid, b_in_valid, ar_in_valid, r_in_valid} = '0;
        {aw_out_ready, w_out_ready, b_out_ready, ar_out_ready, r_out_ready} = '0;
        aw_in_data = '0; w_in_data = '0; b_in_data = '0; ar_in_data = '0; r_in_data = '0;
        #1 ARESETn = 1'b0;
        #2;
        `CHK("reset aw out_valid", aw_out_valid, 1'b0);
        `CHK("reset w out_valid", w_out_valid, 1'b0);
        `CHK("reset r out_valid", r_out_valid, 1'b0);
        `CHK("reset idle", idle, 1'b1);
        `CHK("reset mode1 in_ready", w_in_ready, 1'b1);
        `CHK("reset mode2 in_ready", aw_in_ready, 1'b0);

        for (int p = 0; p < 4; p++) begin
            pv = 2'(p);
            m0_aw_in_valid  = pv[0];
            m0_aw_out_ready = pv[1];
            m0_aw_in_data   = M_AW_PW'(rnd());
            m0_w_in_valid   = pv[0];
            m0_w_out_ready  = pv[1];
            m0_w_in_data    = M_W_PW'(rnd());
            m0_b_in_valid   = pv[0];
            m0_b_out_ready  = pv[1];
            m0_b_in_data    = M_B_PW'(rnd());
            m0_ar_in_valid  = pv[0];
            m0_ar_out_ready = pv[1];
            m0_ar_in_data   = M_AW_PW'(rnd());
            m0_r_in_valid   = pv[0];
            m0_r_out_ready  = pv[1];
            m0_r_in_data    = M_R_PW'(rnd());
            #1;
            `CHK("m0 aw valid", m0_aw_out_valid, pv[0]);
            `CHK("m0 aw data", m0_aw_out_data, m0_aw_in_data);
            `CHK("m0 aw ready", m0_aw_in_ready, pv[1]);
            `CHK("m0 w valid", m0_w_out_valid, pv[0]);
            `CHK("m0 w data", m0_w_out_data, m0_w_in_data);
            `CHK("m0 w ready", m0_w_in_ready, pv[1]);
            `CHK("m0 b valid", m0_b_out_valid, pv[0]);
            `CHK("m0 b data", m0_b_out_data, m0_b_in_data);
            `CHK("m0 b ready", m0_b_in_ready, pv[1]);
            `CHK("m0 ar valid", m0_ar_out_valid, pv[0]);
            `CHK("m0 ar data", m0_ar_out_data, m0_ar_in_data);
            `CHK("m0 ar ready", m0_ar_in_ready, pv[1]);
            `CHK("m0 r valid", m0_r_out_valid, pv[0]);
            `CHK("m0 r data", m0_r_out_data, m0_r_in_data);
            `CHK("m0 r ready", m0_r_in_ready, pv[1]);
            `CHK("m0 idle", m0_idle, 1'b1);
        end

        @(posedge clk); #3;
        ARESETn = 1'b1;
        #1;
        `CHK("release in_ready before edge", aw_in_ready, 1'b0);
        @(posedge clk); #1;
        `CHK("release in_ready after edge", aw_in_ready, 1'b1);

        aw_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            aw_in_valid = 1'b1;
            aw_in_data  = AW_PW'(k);
            @(negedge clk);
            n_chk++;
            if (aw_in_ready === 1'b1) n_pass++;
            else $display("FAIL stream in_ready: got %0h expected 1", aw_in_ready);
            if (k > 0) begin
                n_chk++;
                if (aw_out_valid === 1'b1) n_pass++;
                else $display("FAIL stream out_valid: got %0h expected 1", aw_out_valid);
                n_chk++;
                if (aw_out_data === AW_PW'(k - 1)) n_pass++;
                else $display("FAIL stream out_data: got %0h expected %0h", aw_out_data, k - 1);
            end
            @(posedge clk); #1;
        end
        aw_in_valid = 1'b0;
        @(negedge clk);
        `CHK("stream last data", aw_out_data, AW_PW'(15));
        @(posedge clk); #1;
        aw_out_ready = 1'b0;

        ar_in_valid = 1'b1;
        ar_in_data  = AW_PW'('hA1);
        @(posedge clk); #1;
        ar_in_data  = AW_PW'('hB2);
        @(negedge clk);
        `CHK("fill out_data A", ar_out_data, AW_PW'('hA1));
        @(posedge clk); #1;
        ar_in_valid = 1'b0;
        @(negedge clk);
        `CHK("full in_ready", ar_in_ready, 1'b0);
        `CHK("full idle", idle, 1'b0);
        @(posedge clk); #1;
        ar_out_ready = 1'b1;
        @(negedge clk);
        `CHK("drain first A", ar_out_data, AW_PW'('hA1));
        @(posedge clk); #1;
        @(negedge clk);
        `CHK("drain then B", ar_out_data, AW_PW'('hB2));
        `CHK("drain in_ready back", ar_in_ready, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        `CHK("drain empty", ar_out_valid, 1'b0);
        @(posedge clk); #1;

        ar_out_ready = 1'b0;
        ar_in_valid  = 1'b1;
        ar_in_data   = AW_PW'('hC3);
        @(posedge clk); #1;
        ar_in_data   = AW_PW'('hD4);
        @(posedge clk); #1;
        ar_in_valid  = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        `CHK("async rst out_valid", ar_out_valid, 1'b0);
        `CHK("async rst idle", idle, 1'b1);
        `CHK("async rst in_ready", ar_in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #3 ARESETn = 1'b1;
        @(posedge clk); #1;
        `CHK("post rst in_ready", ar_in_ready, 1'b1);
        ar_out_ready = 1'b1;
        ar_in_valid  = 1'b1;
        ar_in_data   = AW_PW'('hE5);
        @(posedge clk); #1;
        ar_in_valid  = 1'b0;
        @(negedge clk);
        `CHK("post rst beat valid", ar_out_valid, 1'b1);
        `CHK("post rst beat data", ar_out_data, AW_PW'('hE5));
        @(posedge clk); #1;

        rr_en = 1'b1;
        fork
            drv(0, 1500);
            drv(1, 10000);
            drv(2, 1500);
            drv(3, 1500);
            drv(4, 1500);
        join
        rr_en = 1'b0;
        @(posedge clk); #2;
        {aw_out_ready, w_out_ready, b_out_ready, ar_out_ready, r_out_ready} = '1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (mq[c].size() == 0) n_pass++;
            else $display("FAIL drain %s queue: got %0d expected 0", mname[c], mq[c].size());
        end
        n_chk++;
        if (idle === 1'b1) n_pass++;
        else $display("FAIL drain idle: got %0h expected 1", idle);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_register_slice.md
AXI4_REGISTER_SLICE -- requirements
Module: axi4_register_slice

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ID_W, 4, AxID/BID/RID width (1..16).
- ADDR_W, 32, AxADDR width (12..64).
- DATA_W, 32, WDATA/RDATA width (8..1024, power of 2); strobe width is DATA_W/8.
- USER_W, 1, xUSER width per channel (>=1).
- AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE, 2 each, slice mode per channel: 0 pass-through, 1 forward register, 2 full skid.
REQ-002 Payload widths:
- AW_PW = AR_PW = ID_W+ADDR_W+USER_W+29 (LEN 8, SIZE 3, BURST 2, LOCK 1, CACHE 4, PROT 3, QOS 4, REGION 4).
- W_PW = DATA_W+DATA_W/8+1+USER_W.
- B_PW = ID_W+2+USER_W.
- R_PW = ID_W+DATA_W+3+USER_W.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
- ACLK  in  1  global clock, all state on rising edge.
- ARESETn  in  1  global reset, asynchronous assert, active LOW.
REQ-004 Per channel X in {aw, w, b, ar, r}, data flows in->out; aw/w/ar in-side faces the master, b/r in-side faces the slave.
- X_in_valid  in  1  upstream VALID.
- X_in_ready  out  1  upstream READY.
- X_in_data  in  X_PW  upstream payload.
- X_out_valid  out  1  downstream VALID.
- X_out_ready  in  1  downstream READY.
- X_out_data  out  X_PW  downstream payload.
REQ-005 idle  out  1  high when no slice holds data.

Function
REQ-006 Channels are fully independent; there is no ordering or coupling between them.
REQ-007 A transfer occurs on a rising ACLK edge where valid and ready are both high on the same side.
REQ-008 Mode 0: out_valid=in_valid, out_data=in_data, in_ready=out_ready, all combinational; zero latency, no storage.
REQ-009 Mode 1: one register stage holds valid and data.
- in_ready = !out_valid || out_ready (combinational).
- Latency 1 cycle.
- Throughput 1 beat/cycle.
REQ-010 Mode 2: two-entry skid buffer (main, skid).
- States: EMPTY, ONE, FULL.
- in_ready and out_valid are driven directly from flops; no combinational path from out_ready to in_ready.
- Latency 1 cycle; sustained throughput 1 beat/cycle.
REQ-011 Mode 2 transitions:
- EMPTY + in transfer -> ONE; data to main.
- ONE + in only -> FULL; data to skid.
- ONE + out only -> EMPTY.
- ONE + both -> ONE; main reloaded from in.
- FULL + out transfer -> ONE; skid moves to main.
- in_ready = 0 only in FULL.
REQ-012 In modes 1 and 2, out_data is stable and out_valid does not drop while out_valid=1 and out_ready=0 (AXI VALID/payload stability).
REQ-013 Beats are delivered in order, unmodified, with none lost or duplicated.
REQ-014 Payload registers are not reset; only valid/state flops are reset.
REQ-015 idle is combinational: high when every mode-1/2 channel has out_valid=0 (mode-0 channels are ignored).

Reset
REQ-016 ARESETn low asynchronously forces, regardless of ACLK:
- all X_out_valid = 0;
- mode-1 in_ready = 1 (combinational from the cleared out_valid);
- mode-2 in_ready = 0 and state = EMPTY;
- idle = 1.
REQ-017 Mode-2 in_ready rises on the first ACLK edge after ARESETn deasserts; AXI forbids VALID during reset.
REQ-018 Reset mid-burst discards all held beats without emitting partial data.

Verification
REQ-019 Mode 2, out_ready=1, in_valid every cycle with data 0,1,2,... -> out_data 0,1,2,... one cycle later, no bubbles, in_ready constant 1.
REQ-020 Mode 2, out_ready=0, send beats A and B -> state FULL, in_ready=0 on the cycle after B is accepted; then out_ready=1 -> A, then B on consecutive cycles; in_ready=1 the cycle after A leaves.
REQ-021 Mode 1, random in_valid/out_ready at 50% each, 10000 beats -> scoreboard matches in order; out_data never changes while out_valid=1 and out_ready=0.
REQ-022 Mode 0 -> out_valid, out_data and in_ready follow the inputs in the same cycle, with no register delay.
REQ-023 ARESETn pulled low with a mode-2 channel FULL -> out_valid=0 and idle=1 immediately, with no clock edge; after release, the first beat sent emerges correctly.
REQ-024 DATA_W=128, ID_W=8, W_MODE=1, others 2 -> traffic on all five channels is checked simultaneously; no cross-channel interference.
